branch_resolve_ctrl: RTL and testbench
======================================

BRANCH_RESOLVE_CTRL -- requirements
Module: branch_resolve_ctrl

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, meaning the number of cycles flush is held after a taken branch (legal 1..15).
REQ-002 SHALL have parameter CNT_W, default 16, meaning the width of each statistics counter.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 br_valid  input  1  decode offers a branch instruction.
REQ-007 br_ready  output  1  controller accepts the branch this cycle.
REQ-008 funct_3  input  3  branch condition code, RV32I encoding.
REQ-009 pc_in  input  32  PC of the offered branch.
REQ-010 imm_in  input  32  sign-extended branch offset.
REQ-011 cmp_valid  input  1  comparator flags are valid this cycle.
REQ-012 more, even, less  input  1 each  comparator flags, one-hot when cmp_valid=1.
REQ-013 pc_next  output  32  redirect target.
REQ-014 pc_load  output  1  one-cycle strobe: fetch loads pc_next.
REQ-015 flush  output  1  kill younger instructions in fetch/decode.
REQ-016 stall  output  1  hold fetch/decode while a branch is unresolved.
REQ-017 illegal  output  1  one-cycle strobe: funct_3 is 010 or 011.
REQ-018 branch_cnt, taken_cnt  output  CNT_W each  resolved/taken branch counts.

Function
REQ-019 SHALL implement the FSM IDLE, WAIT_CMP, REDIRECT, FLUSH.
REQ-020 IDLE: br_ready=1; on br_valid=1, latch funct_3, pc_in and imm_in, then go to WAIT_CMP.
REQ-021 WAIT_CMP: br_ready=0, stall=1; stay until cmp_valid=1, then evaluate the condition that same cycle.
REQ-022 Taken condition: 000 even; 001 ~even; 100/110 less; 101/111 more|even; 010/011 never taken.
REQ-023 Flags not one-hot while cmp_valid=1: treat as not taken and pulse illegal.
REQ-024 funct_3 010/011: pulse illegal for one cycle in the evaluating cycle; not taken.
REQ-025 Not taken: return to IDLE next cycle; no pc_load, no flush; branch_cnt increments.
REQ-026 Taken: go to REDIRECT; branch_cnt and taken_cnt increment.
REQ-027 REDIRECT lasts exactly one cycle with pc_load=1, flush=1, stall=1, pc_next = latched pc + latched imm (mod 2^32, carry discarded).
REQ-028 FLUSH: flush=1, stall=0; hold for FLUSH_CYCLES-1 cycles via a down-counter; reaching 0 returns to IDLE.
REQ-029 With FLUSH_CYCLES=1, go from REDIRECT straight to IDLE.
REQ-030 br_valid during WAIT_CMP, REDIRECT or FLUSH: ignore it, br_ready=0; decode holds the request.
REQ-031 cmp_valid outside WAIT_CMP: ignore it.
REQ-032 Branch-to-IDLE latency: not taken = 2 cycles after acceptance (minimum); taken = 2+FLUSH_CYCLES cycles (minimum).
REQ-033 pc_next holds its last computed value when pc_load=0.
REQ-034 Counters wrap at 2^CNT_W; when both counters update, they update in the same cycle.
REQ-035 Outputs are registered except br_ready and stall, which are decoded from state.

Reset
REQ-036 On rst_n=0 at a clock edge: state=IDLE; pc_next=0; pc_load, flush, illegal=0; both counters=0; flush counter=0.
REQ-037 Reset during any state, including mid-FLUSH, abandons the branch with no pc_load; br_ready=1 in the first cycle after rst_n rises.

Verification
REQ-038 BEQ: pc_in=0x100, imm_in=0x20, cmp_valid with even=1 -> one-cycle pc_load with pc_next=0x120; flush high 2 cycles; taken_cnt=1.
REQ-039 BNE with even=1 -> no pc_load, no flush; return to IDLE; branch_cnt=1, taken_cnt=0.
REQ-040 BGE, imm_in=0xFFFFFFF0, pc_in=0x8, more=1 -> pc_next=0xFFFFFFF8 (wrap); taken.
REQ-041 funct_3=011 -> illegal pulse of 1 cycle; not taken; with cmp_valid delayed 5 cycles, stall stays high 5 cycles.
REQ-042 rst_n=0 asserted in the FLUSH state -> all outputs 0 and counters 0 next cycle; a new branch is accepted right after release.
REQ-043 br_valid held high through a taken branch -> exactly one accept per instruction; second accept is in the first IDLE cycle.

Source files
------------

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: accepts one decoded branch, waits for the comparator flags,
// then either retires it or redirects fetch and flushes the front end for FLUSH_CYCLES cycles.
module branch_resolve_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       funct_3,
    input  logic [31:0]      pc_in,
    input  logic [31:0]      imm_in,
    input  logic             cmp_valid,
    input  logic             more,
    input  logic             even,
    input  logic             less,
    output logic [31:0]      pc_next,
    output logic             pc_load,
    output logic             flush,
    output logic             stall,
    output logic             illegal,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT_CMP, REDIRECT, FLUSH} state_t;

    localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES - 1);

    state_t            state_q, state_d;
    logic [2:0]        funct_3_q, funct_3_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       imm_q, imm_d;
    logic [31:0]       pc_next_q, pc_next_d;
    logic              pc_load_q, pc_load_d;
    logic              flush_q, flush_d;
    logic              illegal_q, illegal_d;
    logic [CNT_W-1:0]  branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]  taken_cnt_q, taken_cnt_d;
    logic [3:0]        flush_cnt_q, flush_cnt_d;

    logic [1:0]        flag_sum;
    logic              flags_onehot;
    logic              f3_illegal;
    logic              cond_true;

    always_comb begin
        flag_sum     = {1'b0, more} + {1'b0, even} + {1'b0, less};
        flags_onehot = (flag_sum == 2'd1);
        f3_illegal   = (funct_3_q[2:1] == 2'b01);

        case (funct_3_q)
            3'b000:          cond_true = even;
            3'b001:          cond_true = ~even;
            3'b100, 3'b110:  cond_true = less;
            3'b101, 3'b111:  cond_true = more | even;
            default:         cond_true = 1'b0;
        endcase

        state_d      = state_q;
        funct_3_d    = funct_3_q;
        pc_d         = pc_q;
        imm_d        = imm_q;
        pc_next_d    = pc_next_q;
        illegal_d    = 1'b0;
        branch_cnt_d = branch_cnt_q;
        taken_cnt_d  = taken_cnt_q;
        flush_cnt_d  = flush_cnt_q;

        case (state_q)
            IDLE: begin
                if (br_valid) begin
                    funct_3_d = funct_3;
                    pc_d      = pc_in;
                    imm_d     = imm_in;
                    state_d   = WAIT_CMP;
                end
            end
            WAIT_CMP: begin
                if (cmp_valid) begin
                    branch_cnt_d = branch_cnt_q + CNT_W'(1);
                    // Bad flags or a reserved condition code both resolve as not taken
                    illegal_d    = f3_illegal | ~flags_onehot;
                    if (cond_true && flags_onehot && !f3_illegal) begin
                        taken_cnt_d = taken_cnt_q + CNT_W'(1);
                        pc_next_d   = pc_q + imm_q;
                        state_d     = REDIRECT;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            REDIRECT: begin
                if (FLUSH_LOAD == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    flush_cnt_d = FLUSH_LOAD;
                    state_d     = FLUSH;
                end
            end
            FLUSH: begin
                flush_cnt_d = flush_cnt_q - 4'd1;
                if (flush_cnt_q <= 4'd1) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        pc_load_d = (state_d == REDIRECT);
        flush_d   = (state_d == REDIRECT) || (state_d == FLUSH);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_next_q    <= '0;
            pc_load_q    <= 1'b0;
            flush_q      <= 1'b0;
            illegal_q    <= 1'b0;
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
            flush_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_next_q    <= pc_next_d;
            pc_load_q    <= pc_load_d;
            flush_q      <= flush_d;
            illegal_q    <= illegal_d;
            branch_cnt_q <= branch_cnt_d;
            taken_cnt_q  <= taken_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
        end
        funct_3_q <= funct_3_d;
        pc_q      <= pc_d;
        imm_q     <= imm_d;
    end

    assign br_ready   = (state_q == IDLE);
    assign stall      = (state_q == WAIT_CMP) || (state_q == REDIRECT);
    assign pc_next    = pc_next_q;
    assign pc_load    = pc_load_q;
    assign flush      = flush_q;
    assign illegal    = illegal_q;
    assign branch_cnt = branch_cnt_q;
    assign taken_cnt  = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Scoreboard bench for branch_resolve_ctrl: a driver issues branches and queues the outcome
// predicted from the condition rules; a monitor pops one entry per resolved branch.
module tb_branch_resolve_ctrl;

    localparam int F  = 2;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          br_valid = 1'b0;
    logic          br_ready;
    logic [2:0]    funct_3 = '0;
    logic [31:0]   pc_in = '0;
    logic [31:0]   imm_in = '0;
    logic          cmp_valid = 1'b0;
    logic          more = 1'b0, even = 1'b0, less = 1'b0;
    logic [31:0]   pc_next;
    logic          pc_load, flush, stall, illegal;
    logic [CW-1:0] branch_cnt, taken_cnt;

    branch_resolve_ctrl #(.FLUSH_CYCLES(F), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .br_valid(br_valid), .br_ready(br_ready),
        .funct_3(funct_3), .pc_in(pc_in), .imm_in(imm_in),
        .cmp_valid(cmp_valid), .more(more), .even(even), .less(less),
        .pc_next(pc_next), .pc_load(pc_load), .flush(flush), .stall(stall),
        .illegal(illegal), .branch_cnt(branch_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic          taken;
        logic          ill;
        logic [31:0]   tgt;
        logic [CW-1:0] bc;
        logic [CW-1:0] tc;
    } exp_t;

    exp_t          sb[$];
    int            n_checks = 0, n_pass = 0;
    logic [CW-1:0] m_bc = '0, m_tc = '0;
    logic [31:0]   m_last_tgt = '0;
    int            m_taken_total = 0, m_ill_total = 0;
    int            mon_pl = 0, mon_ill = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference outcome straight from the RV32I condition table
    function automatic logic ref_taken(input logic [2:0] f3, input logic [2:0] flg);
        logic m, e, l;
        {m, e, l} = flg;
        if (flg != 3'b100 && flg != 3'b010 && flg != 3'b001) return 1'b0;
        case (f3)
            3'd0:       return e;
            3'd1:       return !e;
            3'd4, 3'd6: return l;
            3'd5, 3'd7: return m || e;
            default:    return 1'b0;
        endcase
    endfunction

    // Called just after a negedge; returns just after the negedge that follows evaluation.
    task automatic issue(input logic [2:0] f3, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [2:0] flg, input int dly, input bit hold,
                         output int acc_cyc);
        exp_t e;
        int waited;
        logic onehot;
        br_valid  = 1'b1;
        funct_3   = f3;
        pc_in     = pc;
        imm_in    = imm;
        cmp_valid = ($urandom % 4 == 0);
        {more, even, less} = 3'($urandom);
        waited = 0;
        acc_cyc = -1;
        while (!br_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!br_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            br_valid  = 1'b0;
            cmp_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        onehot  = (flg == 3'b100 || flg == 3'b010 || flg == 3'b001);
        e.ill   = (f3 == 3'd2 || f3 == 3'd3) || !onehot;
        e.taken = ref_taken(f3, flg);
        e.tgt   = pc + imm;
        m_bc    = m_bc + 1'b1;
        if (e.taken) begin
            m_tc = m_tc + 1'b1;
            m_last_tgt = e.tgt;
            m_taken_total++;
        end
        if (e.ill) m_ill_total++;
        e.bc = m_bc;
        e.tc = m_tc;
        sb.push_back(e);
        @(negedge clk);
        check("ready_low_waiting", 32'(br_ready), 32'd0);
        cmp_valid = 1'b0;
        if (!hold) br_valid = 1'b0;
        for (int i = 0; i < dly; i++) begin
            check("stall_waiting", 32'(stall), 32'd1);
            @(negedge clk);
        end
        cmp_valid = 1'b1;
        {more, even, less} = flg;
        @(negedge clk);
        cmp_valid = 1'b0;
        {more, even, less} = 3'($urandom);
    endtask

    initial begin : monitor
        logic [CW-1:0] prev;
        int frun;
        exp_t e;
        prev = '0;
        frun = 0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                prev = '0;
                frun = 0;
            end else begin
                if (pc_load) mon_pl++;
                if (illegal) mon_ill++;
                if (flush) frun++;
                else if (frun != 0) begin
                    check("flush_length", frun, F);
                    frun = 0;
                end
                if (branch_cnt != prev) begin
                    if (sb.size() == 0) begin
                        check("unexpected_resolve", 32'(branch_cnt), 32'(prev));
                    end else begin
                        e = sb.pop_front();
                        check("branch_cnt", 32'(branch_cnt), 32'(e.bc));
                        check("taken_cnt", 32'(taken_cnt), 32'(e.tc));
                        check("pc_load", 32'(pc_load), 32'(e.taken));
                        check("illegal", 32'(illegal), 32'(e.ill));
                        check("pc_next", pc_next, e.taken ? e.tgt : m_last_tgt);
                    end
                    prev = branch_cnt;
                end
            end
        end
    end

    initial begin : driver
        int a0, a1, t0;
        logic [2:0] flg;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(br_ready), 32'd1);
        check("rst_pc_next", pc_next, 32'd0);
        check("rst_strobes", {29'd0, pc_load, flush, illegal}, 32'd0);
        check("rst_counts", {branch_cnt, taken_cnt}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // BEQ taken, BNE not taken, BGE with wrapping target, reserved code with late flags
        issue(3'd0, 32'h100, 32'h20, 3'b010, 0, 1'b0, a0);
        repeat (3) @(negedge clk);
        issue(3'd1, 32'h300, 32'h40, 3'b010, 1, 1'b0, a0);
        issue(3'd5, 32'h8, 32'hFFFF_FFF0, 3'b100, 2, 1'b0, a0);
        repeat (3) @(negedge clk);
        issue(3'd3, 32'h500, 32'h4, 3'b010, 5, 1'b0, a0);
        issue(3'd0, 32'h600, 32'h8, 3'b110, 0, 1'b0, a0);
        issue(3'd4, 32'h700, 32'h10, 3'b000, 0, 1'b0, a0);

        // Randomized traffic, with br_valid sometimes held across branches
        for (int n = 0; n < 120; n++) begin
            if ($urandom % 4 == 0) flg = 3'($urandom);
            else flg = 3'b001 << ($urandom % 3);
            issue(3'($urandom), $urandom, $urandom, flg, int'($urandom % 5),
                  ($urandom % 8 == 0), a0);
        end
        br_valid = 1'b0;
        repeat (F + 3) @(negedge clk);

        // Held request: second branch is accepted in the first IDLE cycle
        issue(3'd0, 32'h1000, 32'h100, 3'b010, 0, 1'b1, a0);
        issue(3'd1, 32'h2000, 32'h200, 3'b010, 0, 1'b0, a1);
        check("held_accept_gap", a1 - a0, 2 + F);
        repeat (F + 3) @(negedge clk);

        // Reset while flushing
        issue(3'd0, 32'h4400, 32'h44, 3'b010, 0, 1'b0, a0);
        @(negedge clk);
        check("in_flush_state", {30'd0, flush, stall}, 32'h2);
        rst_n = 1'b0;
        sb.delete();
        m_bc = '0;
        m_tc = '0;
        m_last_tgt = '0;
        @(negedge clk);
        check("midflush_rst_strobes", {28'd0, pc_load, flush, illegal, stall}, 32'd0);
        check("midflush_rst_pc_next", pc_next, 32'd0);
        check("midflush_rst_counts", {branch_cnt, taken_cnt}, 32'd0);
        check("midflush_rst_ready", 32'(br_ready), 32'd1);
        rst_n = 1'b1;
        t0 = cyc;
        issue(3'd1, 32'h80, 32'h8, 3'b100, 0, 1'b0, a0);
        check("accept_after_reset", a0, t0);
        repeat (F + 4) @(negedge clk);

        check("pc_load_pulses", mon_pl, m_taken_total);
        check("illegal_pulses", mon_ill, m_ill_total);
        check("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
